key_serial_loader: RTL and testbench

- Provisioning end of the key interface on our locked ISCAS netlists.
- Accepts a key as a serial bit stream under a valid/ready handshake and assembles it in a shadow register.
- Commits the assembled key atomically to a parallel key bus, which drives the keyIn_* inputs of a locked benchmark such as the SFLL/mux-locked c17.
- Until a key is committed, the key bus carries an all-zero (wrong) key, so the locked circuit stays corrupted.

---
 rtl/key_serial_loader_if.sv | 26 ++
 rtl/key_serial_loader.sv | 183 ++++++++++++++++++
 tb/tb_key_serial_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/key_serial_loader_if.sv
// Handshake and key-bus bundle for key_serial_loader.
// master = provisioning side driving the serial stream, slave = loader.
interface key_serial_loader_if #(
    parameter int unsigned KEY_WIDTH = 4
);
    logic                 load_start;
    logic                 abort;
    logic                 sdi;
    logic                 sdi_valid;
    logic                 sdi_ready;
    logic [KEY_WIDTH-1:0] key_out;
    logic                 key_valid;
    logic                 load_done;
    logic                 key_err;
    logic                 locked;

    modport master (
        output load_start, abort, sdi, sdi_valid,
        input  sdi_ready, key_out, key_valid, load_done, key_err, locked
    );

    modport slave (
        input  load_start, abort, sdi, sdi_valid,
        output sdi_ready, key_out, key_valid, load_done, key_err, locked
    );
endinterface

// File: rtl/key_serial_loader.sv
// Serial key loader: shifts a key in MSB first and commits it atomically to the key bus.
// Define KEY_LOADER_PARITY_EN to add an even-parity check with fail counting and lockout.
module key_serial_loader #(
    parameter int unsigned KEY_WIDTH = 4,
    parameter int unsigned MAX_FAIL  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    key_serial_loader_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(KEY_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_WIDTH - 1);

    if (KEY_WIDTH < 2 || KEY_WIDTH > 64 || MAX_FAIL < 1) begin : g_bad_cfg
        $error("key_serial_loader: KEY_WIDTH must be 2..64 and MAX_FAIL at least 1");
    end

`ifdef KEY_LOADER_PARITY_EN
    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK,
        S_COMMIT,
        S_LOCKOUT
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;
`endif

    state_t               state_q, state_d;
    logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 key_valid_q, key_valid_d;
    logic                 load_done_q, load_done_d;
    logic                 ready;
`ifdef KEY_LOADER_PARITY_EN
    logic [FAIL_W-1:0]    fail_q, fail_d;
    logic                 key_err_q, key_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        key_d       = key_q;
        cnt_d       = cnt_q;
        key_valid_d = key_valid_q;
        load_done_d = 1'b0;
        ready       = 1'b0;
`ifdef KEY_LOADER_PARITY_EN
        fail_d      = fail_q;
        key_err_d   = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.load_start && !bus.abort) begin
                    state_d  = S_SHIFT;
                    shadow_d = '0;
                    cnt_d    = '0;
                end
            end

            // abort beats restart, restart beats the bit on the wire
            S_SHIFT: begin
                ready = 1'b1;
                if (bus.abort) begin
                    state_d  = S_IDLE;
                    shadow_d = '0;
                    cnt_d    = '0;
                end else if (bus.load_start) begin
                    shadow_d = '0;
                    cnt_d    = '0;
                end else if (bus.sdi_valid) begin
                    shadow_d = {shadow_q[KEY_WIDTH-2:0], bus.sdi};
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
`ifdef KEY_LOADER_PARITY_EN
                        state_d = S_CHECK;
`else
                        state_d = S_COMMIT;
`endif
                    end
                end
            end

`ifdef KEY_LOADER_PARITY_EN
            S_CHECK: begin
                ready = 1'b1;
                if (bus.abort) begin
                    state_d  = S_IDLE;
                    shadow_d = '0;
                    cnt_d    = '0;
                end else if (bus.load_start) begin
                    state_d  = S_SHIFT;
                    shadow_d = '0;
                    cnt_d    = '0;
                end else if (bus.sdi_valid) begin
                    if (bus.sdi == ^shadow_q) begin
                        state_d = S_COMMIT;
                        fail_d  = '0;
                    end else begin
                        key_err_d = 1'b1;
                        shadow_d  = '0;
                        cnt_d     = '0;
                        fail_d    = fail_q + FAIL_W'(1);
                        if (fail_q == FAIL_LAST) begin
                            state_d     = S_LOCKOUT;
                            key_d       = '0;
                            key_valid_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            S_LOCKOUT: begin
                state_d = S_LOCKOUT;
            end
`endif

            S_COMMIT: begin
                key_d       = shadow_q;
                key_valid_d = 1'b1;
                load_done_d = 1'b1;
                cnt_d       = '0;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            key_q       <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            load_done_q <= 1'b0;
`ifdef KEY_LOADER_PARITY_EN
            fail_q      <= '0;
            key_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            key_q       <= key_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            load_done_q <= load_done_d;
`ifdef KEY_LOADER_PARITY_EN
            fail_q      <= fail_d;
            key_err_q   <= key_err_d;
`endif
        end
    end

    assign bus.sdi_ready = ready;
    assign bus.key_out   = key_q;
    assign bus.key_valid = key_valid_q;
    assign bus.load_done = load_done_q;
`ifdef KEY_LOADER_PARITY_EN
    assign bus.key_err   = key_err_q;
    assign bus.locked    = (state_q == S_LOCKOUT);
`else
    assign bus.key_err   = 1'b0;
    assign bus.locked    = 1'b0;
`endif

endmodule

// File: tb/tb_key_serial_loader.sv
// Directed plus randomized bench for key_serial_loader against a behavioural key model.
// Parity/lockout steps are included when KEY_LOADER_PARITY_EN is defined.
module tb_key_serial_loader;

    localparam int unsigned W  = 4;
    localparam int unsigned MF = 3;
`ifdef KEY_LOADER_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    key_serial_loader_if #(.KEY_WIDTH(W)) bus ();

    key_serial_loader #(
        .KEY_WIDTH(W),
        .MAX_FAIL (MF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: what the key bus should show
    logic [W-1:0] model_key;
    logic         model_valid;
    logic         model_locked;
    int           model_fails;

    task automatic model_reset();
        model_key    = '0;
        model_valid  = 1'b0;
        model_locked = 1'b0;
        model_fails  = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W+4:0] obs, input logic [W+4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed {key,valid,ready,done,err,locked}=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic rdy, input logic done, input logic err);
        check(tag,
              {bus.key_out, bus.key_valid, bus.sdi_ready, bus.load_done, bus.key_err, bus.locked},
              {model_key, model_valid, rdy, done, err, model_locked});
    endtask

    task automatic start();
        bus.load_start = 1'b1;
        bus.sdi_valid  = 1'b1;
        bus.sdi        = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.sdi_valid  = 1'b0;
        expect_out("start", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_bit(input logic b, input int stall, input logic rdy_after);
        repeat (stall) begin
            bus.sdi_valid = 1'b0;
            bus.sdi       = 1'($urandom);
            tick();
            expect_out("stall", 1'b1, 1'b0, 1'b0);
        end
        bus.sdi       = b;
        bus.sdi_valid = 1'b1;
        tick();
        bus.sdi_valid = 1'b0;
        expect_out("bit", rdy_after, 1'b0, 1'b0);
    endtask

    // Shift a whole key (already in SHIFT), optional stall before bit spos, then commit.
    task automatic shift_key(input logic [W-1:0] k, input int spos, input int slen,
                             input int max_stall, input logic poke_commit);
        int st;
        for (int i = 0; i < int'(W); i++) begin
            st = (i == spos) ? slen : int'($urandom_range(0, max_stall));
            send_bit(k[W-1-i], st, (i == int'(W) - 1) ? PAR : 1'b1);
        end
`ifdef KEY_LOADER_PARITY_EN
        bus.sdi       = ($countones(k) % 2) != 0;
        bus.sdi_valid = 1'b1;
        tick();
        bus.sdi_valid = 1'b0;
        model_fails   = 0;
`endif
        expect_out("commit_hold", 1'b0, 1'b0, 1'b0);
        bus.load_start = poke_commit;
        tick();
        bus.load_start = 1'b0;
        model_key   = k;
        model_valid = 1'b1;
        expect_out("commit", 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("post_commit", 1'b0, 1'b0, 1'b0);
    endtask

`ifdef KEY_LOADER_PARITY_EN
    task automatic bad_parity_load(input logic [W-1:0] k);
        start();
        for (int i = 0; i < int'(W); i++) send_bit(k[W-1-i], 0, 1'b1);
        bus.sdi       = ($countones(k) % 2) == 0;
        bus.sdi_valid = 1'b1;
        tick();
        bus.sdi_valid = 1'b0;
        model_fails++;
        if (model_fails >= int'(MF)) begin
            model_locked = 1'b1;
            model_key    = '0;
            model_valid  = 1'b0;
        end
        expect_out("bad_parity", 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("bad_parity_after", 1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        int n;
        rst_n          = 1'b0;
        bus.load_start = 1'b0;
        bus.abort      = 1'b0;
        bus.sdi        = 1'b0;
        bus.sdi_valid  = 1'b0;
        model_reset();
        tick();
        tick();
        expect_out("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // sdi_valid in IDLE is ignored
        bus.sdi_valid = 1'b1;
        bus.sdi       = 1'b1;
        tick();
        bus.sdi_valid = 1'b0;
        expect_out("idle_ignore", 1'b0, 1'b0, 1'b0);

        // Basic load 1011
        start();
        shift_key(4'b1011, -1, 0, 0, 1'b0);

        // Reload 0,1 then abort: previous key kept
        start();
        send_bit(1'b0, 0, 1'b1);
        send_bit(1'b1, 0, 1'b1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        expect_out("abort", 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("abort_idle", 1'b0, 1'b0, 1'b0);

        // Stall of 5 cycles before the second bit
        start();
        shift_key(4'b1100, 1, 5, 0, 1'b0);

        // Restart after 3 bits; the bit presented with load_start is dropped
        start();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0, 1'b1);
        bus.load_start = 1'b1;
        bus.sdi_valid  = 1'b1;
        bus.sdi        = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.sdi_valid  = 1'b0;
        expect_out("restart", 1'b1, 1'b0, 1'b0);
        shift_key(4'b0110, -1, 0, 0, 1'b0);

        // abort and load_start together: abort wins
        start();
        send_bit(1'b1, 0, 1'b1);
        bus.abort      = 1'b1;
        bus.load_start = 1'b1;
        tick();
        bus.abort      = 1'b0;
        bus.load_start = 1'b0;
        expect_out("abort_wins", 1'b0, 1'b0, 1'b0);

        // load_start during COMMIT ignored
        start();
        shift_key(4'b0001, -1, 0, 0, 1'b1);

        // Randomized loads and partial aborts
        for (int r = 0; r < 24; r++) begin
            start();
            if ($urandom_range(0, 3) == 0) begin
                n = int'($urandom_range(1, W - 1));
                for (int j = 0; j < n; j++) send_bit(1'($urandom), int'($urandom_range(0, 2)), 1'b1);
                bus.abort      = 1'b1;
                bus.load_start = 1'($urandom);
                tick();
                bus.abort      = 1'b0;
                bus.load_start = 1'b0;
                expect_out("rnd_abort", 1'b0, 1'b0, 1'b0);
            end else begin
                shift_key(W'($urandom), -1, 0, 3, 1'($urandom));
            end
        end

`ifdef KEY_LOADER_PARITY_EN
        start();
        shift_key(4'b1011, -1, 0, 0, 1'b0);
        bad_parity_load(W'($urandom));
        start();
        shift_key(4'b0101, -1, 0, 1, 1'b0);
        for (int f = 0; f < int'(MF); f++) bad_parity_load(W'($urandom));
        bus.load_start = 1'b1;
        bus.sdi_valid  = 1'b1;
        tick();
        bus.load_start = 1'b0;
        tick();
        bus.sdi_valid  = 1'b0;
        expect_out("locked_ignore", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        expect_out("lockout_reset", 1'b0, 1'b0, 1'b0);
`endif

        // Reset mid-SHIFT wipes the committed key
        start();
        shift_key(4'b1011, -1, 0, 0, 1'b0);
        start();
        send_bit(1'b1, 0, 1'b1);
        send_bit(1'b0, 0, 1'b1);
        rst_n = 1'b0;
        tick();
        model_reset();
        expect_out("reset_mid_shift", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        expect_out("after_reset", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
